// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants shared by the UART receiver, baud generator and
//                receive FIFO.
//                  c_data_w     - received byte width
//                  c_oversample - receiver oversampling factor per bit
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_data_w     = 8;
    localparam int c_oversample = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : DEPTH x DATA_W register array, synchronous write port and
//                asynchronous read port. Contents are not reset.
//  Ports       : clk        - write clock
//                i_wr_en    - write enable
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_addr  - read address
//                o_rd_data  - combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO behind the UART receiver.
//                Captures bytes on the one-cycle rx_valid strobe, flags a
//                sticky overrun when a byte arrives with no free slot.
//  Ports       : Bclk        - oversampling clock (receiver clock)
//                reset_n     - asynchronous active-low reset
//                rx_valid    - write strobe, rx_byte - write data
//                rd_en       - pop request, rd_data - head entry (FWFT)
//                empty/full  - occupancy flags from registered count
//                count       - occupancy 0..DEPTH
//                overrun     - sticky drop flag, clr_overrun clears it
//                almost_full - count >= AF_THRESH watermark
//  Options     : UART_RX_FIFO_ALMOST_FULL_EN - when defined, almost_full is a
//                registered watermark flag; otherwise it is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = c_data_w,
    parameter int AF_THRESH = 12
) (
    input  logic                       Bclk,
    input  logic                       reset_n,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_byte,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic                       almost_full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH+1);

    logic [c_aw-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_aw-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_cw-1:0] r_count_q,  w_count_d;
    logic            r_overrun_q, w_overrun_d;
    logic            w_wr_fire, w_rd_fire, w_ovf_set;

    assign empty   = (r_count_q == '0);
    assign full    = (r_count_q == c_cw'(DEPTH));
    assign count   = r_count_q;
    assign overrun = r_overrun_q;

    always_comb begin
        w_rd_fire   = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a write while full is
        // still accepted when rd_en is high (full implies not empty).
        w_wr_fire   = rx_valid && (!full || rd_en);
        w_ovf_set   = rx_valid && full && !rd_en;

        w_wr_ptr_d  = w_wr_fire ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d  = w_rd_fire ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        w_count_d   = r_count_q + c_cw'(w_wr_fire) - c_cw'(w_rd_fire);

        // Set takes priority over clear so a coincident drop is never lost.
        w_overrun_d = r_overrun_q;
        if (clr_overrun) w_overrun_d = 1'b0;
        if (w_ovf_set)   w_overrun_d = 1'b1;
    end

    always_ff @(posedge Bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_overrun_q <= 1'b0;
        end else begin
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_overrun_q <= w_overrun_d;
        end
    end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic r_almost_full_q, w_almost_full_d;

    // Compared against next-state count so the flag moves with count.
    assign w_almost_full_d = (32'(w_count_d) >= 32'(AF_THRESH));

    always_ff @(posedge Bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_almost_full_q <= 1'b0;
        end else begin
            r_almost_full_q <= w_almost_full_d;
        end
    end

    assign almost_full = r_almost_full_q;
`else
    assign almost_full = 1'b0;
`endif

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (c_aw)
    ) u_mem (
        .clk       (Bclk),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (r_wr_ptr_q),
        .i_wr_data (rx_byte),
        .i_rd_addr (r_rd_ptr_q),
        .o_rd_data (rd_data)
    );

endmodule : uart_rx_fifo
`default_nettype wire
